bcd_disp_mux: RTL and testbench
===============================

Name: bcd_disp_mux

Overview:
- Downstream display stage for the frequency-meter datapath: latches four BCD digits plus a decimal-point mask on a load strobe.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Adds leading-zero blanking, an invalid-digit indication and 16-level brightness PWM.
- Holds the display stable while upstream recomputes; only a load strobe changes the shown value.

Parameters:
N, 18, refresh counter width; digit slot = 2^(N-2) clk cycles; N >= 8

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
load  in  1  single-cycle strobe; latches bcd3..bcd0 and dp_in
bcd3  in  4  most significant BCD digit
bcd2  in  4  BCD digit
bcd1  in  4  BCD digit
bcd0  in  4  least significant BCD digit
dp_in  in  4  decimal-point mask, bit i lights dp of digit i
blank_lz  in  1  1 = enable leading-zero blanking (sampled live)
duty  in  4  brightness, 0 = 1/16 on-time, 15 = full on (sampled live)
an  out  4  anode enables, active-low, an[i] = digit i
sseg  out  8  segments active-low, sseg[7]=dp, sseg[6:0]={g,f,e,d,c,b,a}
err  out  1  1 while any latched digit > 9

Behaviour:
- Reset: refresh counter = 0; latched digits = 0; dp mask = 0; loaded flag = 0; an = 4'b1111; sseg = 8'hFF; err = 0.
- Refresh counter: free-running N-bit up counter, wraps 2^N-1 -> 0.
- Slot select: sel = cnt[N-1:N-2]; sel = i drives digit i.
- PWM phase: sub = cnt[N-3:N-6]; the selected anode is on only while sub <= duty.
- Load: when load is high at an edge, the latch captures bcd3..0 and dp_in and loaded is set, at that edge.
- Load with reset: reset dominates.
- Load repeated every cycle: last value wins.
- Output timing: an and sseg are registered from the latch and counter; latency is 1 clk.
  - Data loaded at edge k appears on an/sseg at edge k+1.
  - A slot change at edge k appears at edge k+1.
- Before first load: loaded = 0, so an = 4'b1111 and sseg = 8'hFF constantly.
- Segment code, active-low, bit order g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes A..F display '-' = 0111111
- err = OR over the latched digits of (digit > 9); it updates with the latch.
- Leading-zero blanking, only when blank_lz = 1:
  - digit3 blanked if d3 = 0
  - digit2 blanked if d3 = d2 = 0
  - digit1 blanked if d3 = d2 = d1 = 0
  - digit0 is never blanked
  - a digit whose dp bit is set, and every digit right of it, is never blanked
  - dp on digit 1 with value 0005 shows " 0.5" style
- Blanked digit: its anode stays high (off) for its whole slot; sseg = 8'hFF.
- dp bit i drives sseg[7] low while digit i is active.
- Anode mask: at most one an bit is low at any time; an = 4'b1111 during PWM off-phase.
- Live inputs: duty and blank_lz changes take effect from the next clk, 1 cycle later on outputs.
- Reset mid-scan: outputs return to the reset values asynchronously; the latched value is lost.

Decomposition:
- Shared package: the ten digit segment constants, SEG_DASH = 7'b0111111, SEG_OFF = 8'hFF.
- Sub-module bcd_to_sseg: combinational, 4-bit digit + dp -> 8-bit active-low pattern; invalid codes map to dash.
- Top level holds the counter, latch, blanking logic and output registers.

Test Plan:
- Reset then no load, N=8, 600 cycles -> an = 4'b1111 and sseg = 8'hFF throughout.
- N=8, duty = 15, blank_lz = 0, load 1,2,3,4 (bcd3..0) -> each 64-cycle slot in order an = 1110/1101/1011/0111.
  - sseg[6:0] per slot = 0011001/0110000/0100100/1111001.
  - First valid output one cycle after load.
- blank_lz = 1, load 0,0,0,7, dp_in = 0 -> only the an[0] slot lights, showing 1111000; digits 3..1 slots show an = 1111.
- blank_lz = 1, load 0,0,0,5, dp_in = 0010 -> digit1 shows 0 with sseg[7] = 0, digit0 shows 5; digits 3,2 are blank.
- Load bcd2 = 4'hC -> err = 1 the cycle after load; digit2 shows 0111111; a reload with valid digits clears err.
- duty = 3, N=8 -> within each slot an is active for 16 of 64 cycles (sub 0..3 of each 16-cycle sub-period pattern); duty = 15 -> 64 of 64.
- Assert reset mid-slot -> an = 1111, sseg = FF immediately; after release, display stays blank until the next load.

Source files
------------

// File: rtl/bcd_disp_mux_pkg.sv
// -----------------------------------------------------------------------------
// bcd_disp_mux_pkg
//   Shared constants for the BCD seven-segment display stage.
//   Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
//   SEG_DASH is shown for non-decimal codes A..F; SEG_OFF is the full 8-bit
//   pattern (dp included) of a dark digit.
// -----------------------------------------------------------------------------
package bcd_disp_mux_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

endpackage

// File: rtl/bcd_disp_mux_bcd_to_sseg.sv
// -----------------------------------------------------------------------------
// bcd_to_sseg
//   Combinational BCD digit to active-low seven-segment decoder.
//   Ports:
//     digit  in  4  BCD value; codes A..F decode to a dash
//     dp     in  1  1 = light the decimal point
//     seg    out 8  active-low pattern, seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_sseg
  import bcd_disp_mux_pkg::*;
(
  input  bcd_t       digit,
  input  logic       dp,
  output logic [7:0] seg
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    seg = {~dp, SEG_DASH};
    unique case (digit)
      4'd0:    seg[6:0] = SEG_0;
      4'd1:    seg[6:0] = SEG_1;
      4'd2:    seg[6:0] = SEG_2;
      4'd3:    seg[6:0] = SEG_3;
      4'd4:    seg[6:0] = SEG_4;
      4'd5:    seg[6:0] = SEG_5;
      4'd6:    seg[6:0] = SEG_6;
      4'd7:    seg[6:0] = SEG_7;
      4'd8:    seg[6:0] = SEG_8;
      4'd9:    seg[6:0] = SEG_9;
      default: seg[6:0] = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_mux.sv
// -----------------------------------------------------------------------------
// bcd_disp_mux
//   Latches four BCD digits and a decimal-point mask on a load strobe and
//   time-multiplexes them onto a 4-digit common-anode seven-segment display,
//   with leading-zero blanking, invalid-digit flag and 16-level brightness PWM.
//   Ports:
//     clk       in   1  system clock
//     reset     in   1  asynchronous, active-high reset
//     load      in   1  strobe; captures bcd3..bcd0 and dp_in
//     bcd3..0   in   4  digits, bcd3 most significant
//     dp_in     in   4  decimal-point mask, bit i = digit i
//     blank_lz  in   1  enable leading-zero blanking (live)
//     duty      in   4  brightness, on while PWM phase <= duty (live)
//     an        out  4  active-low anode enables, an[i] = digit i
//     sseg      out  8  active-low segments, sseg[7] = dp
//     err       out  1  some latched digit is above 9
//   Parameter N: refresh counter width, digit slot = 2^(N-2) clocks, N >= 8.
// -----------------------------------------------------------------------------
module bcd_disp_mux
  import bcd_disp_mux_pkg::*;
#(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  input  logic [3:0] duty,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       err
);

  logic [N-1:0]      cnt;
  logic [3:0][3:0]   digits_q;   // digits_q[i] = digit i
  logic [3:0]        dp_q;
  logic              loaded_q;

  logic [1:0]        sel;
  logic [3:0]        sub;
  logic [3:0]        keep;       // keep[i]: digit i is significant
  logic              pwm_on;
  logic [7:0]        dec_seg;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      loaded_q <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt <= cnt + N'(1);
      if (load) begin
        digits_q <= {bcd3, bcd2, bcd1, bcd0};
        dp_q     <= dp_in;
        loaded_q <= 1'b1;
        err      <= (bcd3 > 4'd9) | (bcd2 > 4'd9) | (bcd1 > 4'd9) | (bcd0 > 4'd9);
      end
    end
  end

  assign sel    = cnt[N-1:N-2];
  assign sub    = cnt[N-3:N-6];
  assign pwm_on = (sub <= duty);

  // A digit stays lit once it or anything to its left is non-zero or carries
  // a decimal point; digit 0 always stays lit.
  assign keep[3] = (digits_q[3] != 4'd0) | dp_q[3];
  assign keep[2] = keep[3] | (digits_q[2] != 4'd0) | dp_q[2];
  assign keep[1] = keep[2] | (digits_q[1] != 4'd0) | dp_q[1];
  assign keep[0] = 1'b1;

  bcd_to_sseg u_dec (
    .digit (digits_q[sel]),
    .dp    (dp_q[sel]),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= 4'hF;
      sseg <= SEG_OFF;
    end else if (!loaded_q || (blank_lz && !keep[sel])) begin
      an   <= 4'hF;
      sseg <= SEG_OFF;
    end else begin
      // Segments follow the slot; only the anode is gated by the PWM phase.
      an   <= pwm_on ? ~(4'b0001 << sel) : 4'hF;
      sseg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_disp_mux
//   Self-checking bench for bcd_disp_mux with N = 8 (64-cycle digit slots).
//   A reference model computes each expected output from the counter value
//   with plain arithmetic and a segment lookup; directed steps are followed
//   by randomized loads, digits, masks, duty and blanking.
// -----------------------------------------------------------------------------
module tb_bcd_disp_mux;

  localparam int N    = 8;
  localparam int SLOT = 1 << (N - 2);
  localparam int PHASE = SLOT / 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       load = 1'b0;
  logic [3:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic [3:0] dp_in = '0;
  logic       blank_lz = 1'b0;
  logic [3:0] duty = 4'd15;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       err;

  int errors = 0;
  int checks = 0;

  bcd_disp_mux #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .bcd3     (bcd3),
    .bcd2     (bcd2),
    .bcd1     (bcd1),
    .bcd0     (bcd0),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .duty     (duty),
    .an       (an),
    .sseg     (sseg),
    .err      (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cnt;
  int         m_d [4];
  logic [3:0] m_dp;
  bit         m_loaded;
  bit         m_err;
  logic [3:0] exp_an;
  logic [7:0] exp_sseg;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    = 0;
      m_d      = '{0, 0, 0, 0};
      m_dp     = '0;
      m_loaded = 0;
      m_err    = 0;
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
    end else begin
      int sel, sub, first;
      sel   = m_cnt / SLOT;
      sub   = (m_cnt % SLOT) / PHASE;
      // leftmost position that must be shown
      first = 0;
      for (int i = 3; i >= 1; i--)
        if (first == 0 && (m_d[i] != 0 || m_dp[i])) first = i;
      if (!m_loaded || (blank_lz && sel > first)) begin
        exp_an   = 4'hF;
        exp_sseg = 8'hFF;
      end else begin
        exp_sseg = {~m_dp[sel], seg_of(m_d[sel])};
        exp_an   = 4'hF;
        if (sub <= int'(duty)) exp_an[sel] = 1'b0;
      end
      m_cnt = (m_cnt + 1) % (1 << N);
      if (load) begin
        m_d      = '{int'(bcd0), int'(bcd1), int'(bcd2), int'(bcd3)};
        m_dp     = dp_in;
        m_loaded = 1;
        m_err    = (bcd3 > 9) || (bcd2 > 9) || (bcd1 > 9) || (bcd0 > 9);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".an"},   {28'd0, an},   {28'd0, exp_an});
    check({tag, ".sseg"}, {24'd0, sseg}, {24'd0, exp_sseg});
    check({tag, ".err"},  {31'd0, err},  {31'd0, m_err});
  endtask

  // advance n cycles, comparing against the model after every edge
  task automatic run(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check_model(tag);
    end
  endtask

  task automatic do_load(input logic [3:0] d3, d2, d1, d0, input logic [3:0] dp);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; dp_in = dp;
    load = 1'b1;
    @(negedge clk);
    check_model("load");
    load = 1'b0;
  endtask

  // count cycles in a 4-slot frame where each anode is low
  task automatic count_frame(output int on_cnt [4]);
    on_cnt = '{0, 0, 0, 0};
    repeat (4 * SLOT) begin
      @(negedge clk);
      check_model("frame");
      for (int i = 0; i < 4; i++) if (an[i] === 1'b0) on_cnt[i]++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnts [4];

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.an",   {28'd0, an},   32'hF);
    check("reset.sseg", {24'd0, sseg}, 32'hFF);
    check("reset.err",  {31'd0, err},  32'd0);
    reset = 1'b0;

    // no load yet: display dark throughout
    run("noload", 600);
    check("noload.an", {28'd0, an}, 32'hF);

    // 1,2,3,4 full brightness, no blanking
    duty = 4'd15; blank_lz = 1'b0;
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    count_frame(cnts);
    for (int i = 0; i < 4; i++) check($sformatf("full.on%0d", i), cnts[i], SLOT);

    // duty 3: a quarter of each slot
    duty = 4'd3;
    count_frame(cnts);
    for (int i = 0; i < 4; i++) check($sformatf("duty3.on%0d", i), cnts[i], SLOT / 4);

    // leading-zero blanking: only digit 0 lights
    duty = 4'd15; blank_lz = 1'b1;
    do_load(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    count_frame(cnts);
    check("lz7.on0", cnts[0], SLOT);
    check("lz7.on123", cnts[1] + cnts[2] + cnts[3], 0);

    // dp on digit 1 keeps it lit: " 0.5"
    do_load(4'd0, 4'd0, 4'd0, 4'd5, 4'b0010);
    count_frame(cnts);
    check("lzdp.on0", cnts[0], SLOT);
    check("lzdp.on1", cnts[1], SLOT);
    check("lzdp.on23", cnts[2] + cnts[3], 0);

    // invalid digit flags err and shows a dash; a valid reload clears it
    blank_lz = 1'b0;
    do_load(4'd9, 4'hC, 4'd0, 4'd1, 4'b0000);
    check("err.set", {31'd0, err}, 32'd1);
    run("err.scan", 4 * SLOT);
    do_load(4'd9, 4'd8, 4'd0, 4'd1, 4'b0000);
    check("err.clr", {31'd0, err}, 32'd0);

    // back-to-back loads: last one wins
    bcd3 = 4'd3; bcd2 = 4'd3; bcd1 = 4'd3; bcd0 = 4'd3; load = 1'b1;
    @(negedge clk); check_model("b2b");
    bcd3 = 4'd6; bcd2 = 4'd0; bcd1 = 4'hF; bcd0 = 4'd2;
    @(negedge clk); check_model("b2b");
    load = 1'b0;
    run("b2b", 2 * SLOT);

    // randomized loads, masks, duty and blanking
    for (int k = 0; k < 40; k++) begin
      logic [3:0] r [4];
      for (int i = 0; i < 4; i++)
        r[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      duty     = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      do_load(r[3], r[2], r[1], r[0], ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom));
      run("rand", $urandom_range(5, 150));
    end

    // asynchronous reset in the middle of a slot
    duty = 4'd15; blank_lz = 1'b0;
    do_load(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111);
    run("prereset", SLOT + 10);
    #2 reset = 1'b1;
    #1;
    check("midreset.an",   {28'd0, an},   32'hF);
    check("midreset.sseg", {24'd0, sseg}, 32'hFF);
    check("midreset.err",  {31'd0, err},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_frame(cnts);
    check("postreset.dark", cnts[0] + cnts[1] + cnts[2] + cnts[3], 0);
    do_load(4'd0, 4'd4, 4'd2, 4'd0, 4'b0100);
    run("reload", 4 * SLOT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
